// File: rtl/xdiv.sv
// Memory-mapped radix-2 restoring divider, one quotient bit per clock.
// Unsigned or signed (truncating) division selected per start command.
module xdiv #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [ADDR_W-1:0] A_DVD  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_DVS  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_QUO  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_REM  = ADDR_W'(4);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [DATA_W-1:0] dividend;
   logic [DATA_W-1:0] divisor;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;
   logic              busy;
   logic              done;
   logic              dz;
   logic              sgn_mode;

   logic [DATA_W-1:0] rem_w;
   logic [DATA_W-1:0] quo_w;
   logic [DATA_W-1:0] dvs_w;
   logic              neg_q;
   logic              neg_r;
   logic [CNT_W-1:0]  cnt;

   logic              wr;
   logic              start;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   diff;
   logic              borrow;
   logic [DATA_W-1:0] rem_nx;
   logic [DATA_W-1:0] quo_nx;

   assign wr    = sel & we;
   assign start = wr && addr == A_CTRL && data_in[0];

   // Signed mode works on magnitudes; the most-negative value maps to itself.
   assign a_neg = data_in[1] & dividend[DATA_W-1];
   assign b_neg = data_in[1] & divisor[DATA_W-1];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;

   assign rem_sh = {rem_w, quo_w[DATA_W-1]};
   assign diff   = rem_sh - {1'b0, dvs_w};
   assign borrow = diff[DATA_W];
   assign rem_nx = borrow ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
   assign quo_nx = {quo_w[DATA_W-2:0], ~borrow};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dividend  <= '0;
         divisor   <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dz        <= 1'b0;
         sgn_mode  <= 1'b0;
         rem_w     <= '0;
         quo_w     <= '0;
         dvs_w     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         cnt       <= '0;
      end else begin
         if (wr && addr == A_DVD) dividend <= data_in;
         if (wr && addr == A_DVS) divisor <= data_in;
         case (state)
            IDLE: begin
               if (start) begin
                  sgn_mode <= data_in[1];
                  done     <= 1'b0;
                  dz       <= 1'b0;
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     dz        <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     rem_w <= '0;
                     quo_w <= a_mag;
                     dvs_w <= b_mag;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     busy  <= 1'b1;
                     cnt   <= CNT_W'(DATA_W - 1);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem_w <= rem_nx;
               quo_w <= quo_nx;
               if (cnt == '0) begin
                  quotient  <= neg_q ? -quo_nx : quo_nx;
                  remainder <= neg_r ? -rem_nx : rem_nx;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      data_out = '0;
      if (sel) begin
         case (addr)
            A_DVD:   data_out = dividend;
            A_DVS:   data_out = divisor;
            A_CTRL:  data_out = {{(DATA_W-4){1'b0}}, sgn_mode, dz, done, busy};
            A_QUO:   data_out = quotient;
            A_REM:   data_out = remainder;
            default: data_out = '0;
         endcase
      end
   end

endmodule
